uart_tx_fifo: RTL

//  Memory-mapped UART transmit stage downstream of the core's UART IO register.
//  - Accepts bytes on a single-cycle send strobe into a small FIFO.
//  - Serializes each byte as 8N1 (1 start, 8 data LSB-first, 1 stop) on a line held idle-high.
//  - Reports back-pressure to the core on tx_busy; software polls it through the UART CSR.

---
 rtl/uart_tx_fifo.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmit stage: a small byte FIFO feeding an 8N1 serializer on an idle-high line.
// tx is registered; tx_busy/tx_idle/fifo_level decode directly from registered state.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          send,
  input  logic [31:0]                   data_in,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_idle,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [7:0]  shift_q, shift_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        overflow_q, overflow_d;
  logic        full_s, empty_s, push_s, pop_s, bit_done_s;
  logic        unused_upper_s;

  assign full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_s    = (wr_ptr_q == rd_ptr_q);
  assign bit_done_s = (cnt_q == BIT_LAST);
  // A send while full is dropped even if the serializer pops on the same edge.
  assign push_s     = send && !full_s;

  assign tx             = tx_q;
  assign tx_busy        = full_s;
  assign tx_idle        = empty_s && (state_q == ST_IDLE);
  assign fifo_level     = wr_ptr_q - rd_ptr_q;
  assign overflow       = overflow_q;
  assign unused_upper_s = ^data_in[31:8];

  // FIFO write side, pointer updates and sticky overflow
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_in[7:0];
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (send && full_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Serializer next-state, baud counter, shift register and next line level
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop_s     = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rd_ptr_q[AW-1:0]];
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          cnt_d     = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          cnt_d     = 16'd0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          state_d   = (bit_idx_q == 3'd7) ? ST_STOP : ST_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_done_s) begin
          cnt_d = 16'd0;
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rd_ptr_q[AW-1:0]];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = ST_IDLE;
      end
    endcase
    // Line level follows the state being entered so tx changes on the same edge.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and flushes the queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shift_q    <= 8'd0;
      cnt_q      <= 16'd0;
      bit_idx_q  <= 3'd0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
